// File: rtl/udsp_sched_pkg.sv
// Shared types and default constants for the uDSP frame scheduler.
// No logic; no latency; no backpressure.
package udsp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DAW_DEF        = 10;
    localparam int DWW_DEF        = 36;
    localparam int RUN_CYCLES_DEF = 516;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int OVR_W_DEF      = 8;

endpackage

// File: rtl/udsp_wr_fifo.sv
// Generic synchronous FIFO buffering host writes; head entry visible on dout.
// Latency: one cycle from push to visible head; full/empty registered from occupancy.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
module udsp_wr_fifo #(
    parameter int W     = 46,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full_q || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/udsp_frame_scheduler.sv
// Starts the uDSP once per sample tick, runs it for a fixed budget, muxes the memory write port.
// Latency: START 1 cycle, RUN RUN_CYCLES cycles, DONE 1 cycle; mem_* mux is combinational.
// Backpressure: host_ready drops when the write buffer is full; ticks while busy are dropped and counted.
module udsp_frame_scheduler
    import udsp_sched_pkg::*;
#(
    parameter int DAW        = DAW_DEF,
    parameter int DWW        = DWW_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int OVR_W      = OVR_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_tick,
    output logic             dsp_start,
    output logic             busy,
    output logic             frame_done,
    output logic [OVR_W-1:0] overrun_count,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [DAW-1:0]   host_addr,
    input  logic [DWW-1:0]   host_data,
    input  logic [DAW-1:0]   dsp_addrW,
    input  logic [DWW-1:0]   dsp_dataW,
    input  logic             dsp_writeEn,
    output logic [DAW-1:0]   mem_addrW,
    output logic [DWW-1:0]   mem_dataW,
    output logic             mem_writeEn
);

    localparam int CW = $clog2(RUN_CYCLES);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             dsp_start_q, dsp_start_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             rdy_q;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DAW+DWW-1:0] fifo_dout;
    logic             core_owns_port;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE:  if (sample_tick) state_d = START;
            START: begin
                cnt_d   = CW'(RUN_CYCLES - 1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE:  state_d = IDLE;
        endcase
        if (sample_tick && state_q != IDLE && ovr_q != '1) ovr_d = ovr_q + OVR_W'(1);
        // Outputs are registered from the next state so they line up with it.
        dsp_start_d  = (state_d == START);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ovr_q        <= '0;
            dsp_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovr_q        <= ovr_d;
            dsp_start_q  <= dsp_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rdy_q        <= 1'b1;
        end
    end

    assign fifo_push = host_valid && host_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    udsp_wr_fifo #(
        .W     (DAW + DWW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     ({host_addr, host_data}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The core free-runs past its budget, so its writes only count in RUN/DONE.
    assign core_owns_port = (state_q == RUN) || (state_q == DONE);

    always_comb begin
        mem_writeEn = 1'b0;
        mem_addrW   = '0;
        mem_dataW   = '0;
        if (core_owns_port) begin
            mem_writeEn = dsp_writeEn;
            mem_addrW   = dsp_addrW;
            mem_dataW   = dsp_dataW;
        end else if (fifo_pop) begin
            mem_writeEn = 1'b1;
            {mem_addrW, mem_dataW} = fifo_dout;
        end
    end

    assign dsp_start     = dsp_start_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign overrun_count = ovr_q;
    assign host_ready    = rdy_q && !fifo_full;

endmodule

// File: tb/tb_udsp_frame_scheduler.sv
// Randomised and directed stimulus for udsp_frame_scheduler checked cycle by cycle
// against a frame-phase / queue reference model.
module tb_udsp_frame_scheduler;

    localparam int DAW   = 10;
    localparam int DWW   = 36;
    localparam int RUN   = 8;
    localparam int DEPTH = 8;
    localparam int OVR_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sample_tick;
    logic             dsp_start, busy, frame_done;
    logic [OVR_W-1:0] overrun_count;
    logic             host_valid, host_ready;
    logic [DAW-1:0]   host_addr;
    logic [DWW-1:0]   host_data;
    logic [DAW-1:0]   dsp_addrW;
    logic [DWW-1:0]   dsp_dataW;
    logic             dsp_writeEn;
    logic [DAW-1:0]   mem_addrW;
    logic [DWW-1:0]   mem_dataW;
    logic             mem_writeEn;

    udsp_frame_scheduler #(
        .DAW(DAW), .DWW(DWW), .RUN_CYCLES(RUN), .FIFO_DEPTH(DEPTH), .OVR_W(OVR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .dsp_start(dsp_start), .busy(busy), .frame_done(frame_done),
        .overrun_count(overrun_count),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .dsp_addrW(dsp_addrW), .dsp_dataW(dsp_dataW), .dsp_writeEn(dsp_writeEn),
        .mem_addrW(mem_addrW), .mem_dataW(mem_dataW), .mem_writeEn(mem_writeEn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame phase (0 idle, 1 start, 2..RUN+1 run, RUN+2 done),
    // pending host writes in push order, and the dropped-tick count.
    int                 ph  = 0;
    int                 ovr = 0;
    logic [DAW+DWW-1:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit          rdy, pop, pass;
        logic [63:0] e_we, e_a, e_d;
        @(negedge clk);
        rdy  = (q.size() < DEPTH);
        pass = (ph >= 2);
        pop  = (ph == 0) && (q.size() > 0);
        e_we = 0; e_a = 0; e_d = 0;
        if (pass) begin
            e_we = dsp_writeEn; e_a = dsp_addrW; e_d = dsp_dataW;
        end else if (pop) begin
            e_we = 1; e_a = q[0][DWW +: DAW]; e_d = q[0][DWW-1:0];
        end
        chk("mem_we",     mem_writeEn,   e_we);
        chk("mem_addr",   mem_addrW,     e_a);
        chk("mem_data",   mem_dataW,     e_d);
        chk("dsp_start",  dsp_start,     ph == 1);
        chk("busy",       busy,          ph != 0);
        chk("frame_done", frame_done,    ph == RUN + 2);
        chk("overrun",    overrun_count, ovr);
        chk("host_ready", host_ready,    rdy);
        if (pop) void'(q.pop_front());
        if (host_valid && rdy) q.push_back({host_addr, host_data});
        if (sample_tick && ph != 0) ovr = (ovr == 255) ? 255 : ovr + 1;
        if (ph == 0)            ph = sample_tick ? 1 : 0;
        else if (ph == RUN + 2) ph = 0;
        else                    ph = ph + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_mem_we",     mem_writeEn,   0);
        chk("rst_mem_addr",   mem_addrW,     0);
        chk("rst_mem_data",   mem_dataW,     0);
        chk("rst_dsp_start",  dsp_start,     0);
        chk("rst_busy",       busy,          0);
        chk("rst_frame_done", frame_done,    0);
        chk("rst_overrun",    overrun_count, 0);
        chk("rst_host_ready", host_ready,    0);
        sample_tick = 0; host_valid = 0; dsp_writeEn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        ph  = 0;
        ovr = 0;
    endtask

    initial begin
        int n;
        reset_n = 1'b1; sample_tick = 0; host_valid = 0;
        host_addr = '0; host_data = '0; dsp_addrW = '0; dsp_dataW = '0; dsp_writeEn = 0;
        #2;
        do_reset();

        // Three host writes applied while idle, back to back.
        for (int i = 0; i < 3; i++) begin
            host_valid = 1; host_addr = DAW'(10'h010 + i); host_data = DWW'(i + 1);
            step();
        end
        host_valid = 0;
        repeat (4) step();

        // One frame with core writeback to 0x020.
        dsp_addrW = 10'h020; dsp_dataW = 36'h5; dsp_writeEn = 1;
        sample_tick = 1; step(); sample_tick = 0;
        repeat (RUN + 4) step();

        // Host writes during RUN are held until idle; core writes keep trying in idle.
        sample_tick = 1; step(); sample_tick = 0;
        step(); step();
        host_valid = 1; host_addr = 10'h030; host_data = 36'hA; step();
        host_addr = 10'h031; host_data = 36'hB; step();
        host_valid = 0;
        repeat (RUN + 4) step();
        dsp_writeEn = 0;

        // Nine writes while busy: buffer fills at eight, ninth waits for the drain.
        sample_tick = 1; step(); sample_tick = 0;
        n = 0;
        for (int k = 0; k < 40 && n < 9; k++) begin
            host_valid = 1; host_addr = DAW'(10'h040 + n); host_data = DWW'(36'h100 + n);
            if (q.size() < DEPTH) n++;
            step();
        end
        host_valid = 0;
        repeat (12) step();

        // Tick at +0 and +5: the second is dropped.
        sample_tick = 1; step(); sample_tick = 0;
        repeat (4) step();
        sample_tick = 1; step(); sample_tick = 0;
        repeat (RUN + 4) step();
        chk("ovr_one", overrun_count, 1);

        // Continuous ticks drive the counter to saturation.
        sample_tick = 1;
        repeat (300) step();
        sample_tick = 0;
        repeat (RUN + 4) step();
        chk("ovr_sat", overrun_count, 255);

        // Reset mid-RUN with three entries pending.
        sample_tick = 1; step(); sample_tick = 0;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1; host_addr = DAW'(10'h050 + i); host_data = DWW'(36'h200 + i);
            step();
        end
        host_valid = 0; dsp_writeEn = 1; dsp_addrW = 10'h3FF; dsp_dataW = 36'h123;
        step();
        do_reset();
        dsp_writeEn = 1;
        repeat (RUN + 4) step();
        dsp_writeEn = 0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            sample_tick = ($urandom_range(0, 19) == 0);
            host_valid  = ($urandom_range(0, 2) == 0);
            host_addr   = DAW'($urandom);
            host_data   = DWW'({$urandom, $urandom});
            dsp_writeEn = $urandom_range(0, 1) == 1;
            dsp_addrW   = DAW'($urandom);
            dsp_dataW   = DWW'({$urandom, $urandom});
            step();
        end
        sample_tick = 0; host_valid = 0; dsp_writeEn = 0;
        repeat (RUN + DEPTH + 4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
